// File: rtl/prog_freq_div.sv
// prog_freq_div -- bank of NCH independent programmable clock dividers.
//
// Each channel runs a phase counter 0..D-1 and produces a registered divided
// clock (low for ceil(D/2) cycles, high for the rest), a one-cycle TICK on
// each divided-clock rising edge, and a BUSY flag while a newly written
// divisor waits for the next period boundary to take effect.
//
// Ports
//   CLK_in   in  1    clock, all logic on rising edge
//   RST      in  1    asynchronous active-high reset
//   EN       in  NCH  per-channel run enable
//   DIV_WR   in  1    divisor write strobe
//   DIV_SEL  in  4    channel index for the write
//   DIV_VAL  in  DW   divisor value for the write (must be >= 2)
//   CLK_OUT  out NCH  divided clocks
//   TICK     out NCH  pulse on each CLK_OUT rising edge
//   BUSY     out NCH  divisor update pending
//   ERR      out 1    pulse for a rejected write

// One divider channel.
module prog_freq_div_ch #(
  parameter int DW      = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          CLK_in,
  input  logic          RST,
  input  logic          en,
  input  logic          wr,      // accepted write addressed to this channel
  input  logic [DW-1:0] wval,
  output logic          clk_out,
  output logic          tick,
  output logic          busy
);
  localparam logic [DW-1:0] DEF = DW'(DEF_DIV);

  logic [DW-1:0] d, p, cnt, cnt_nx;
  logic [DW:0]   h;
  logic          wrap, apply;

  always_comb begin
    // Computed one bit wider so D = 2^DW-1 does not overflow.
    h      = ({1'b0, d} + (DW+1)'(1)) >> 1;
    wrap   = (cnt == d - DW'(1));
    cnt_nx = wrap ? '0 : cnt + DW'(1);
    // Divisor only changes on a period boundary, or immediately when idle.
    apply  = busy && (wrap || !en);
  end

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      d       <= DEF;
      p       <= DEF;
      cnt     <= '0;
      busy    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (en) begin
        cnt     <= cnt_nx;
        clk_out <= ({1'b0, cnt_nx} >= h);
        tick    <= ({1'b0, cnt_nx} == h);
      end else begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
      if (apply) begin
        d    <= p;
        busy <= 1'b0;
      end
      // A write landing on the apply edge becomes the next pending value;
      // ordering after the apply keeps BUSY set.
      if (wr) begin
        p    <= wval;
        busy <= 1'b1;
      end
    end
  end
endmodule

module prog_freq_div #(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int DEF_DIV = 2
) (
  input  logic           CLK_in,
  input  logic           RST,
  input  logic [NCH-1:0] EN,
  input  logic           DIV_WR,
  input  logic [3:0]     DIV_SEL,
  input  logic [DW-1:0]  DIV_VAL,
  output logic [NCH-1:0] CLK_OUT,
  output logic [NCH-1:0] TICK,
  output logic [NCH-1:0] BUSY,
  output logic           ERR
);
  localparam logic [4:0] NCH_L = 5'(NCH);

  logic           rel_edge;   // set by reset, cleared on first clock after release
  logic           sel_ok, val_ok, wr_q, wr_ok;
  logic [NCH-1:0] ch_wr;

  always_comb begin
    sel_ok = ({1'b0, DIV_SEL} < NCH_L);
    val_ok = (DIV_VAL >= DW'(2));
    // Writes on the reset-release edge are dropped entirely (no ERR either).
    wr_q   = DIV_WR && !rel_edge;
    wr_ok  = wr_q && sel_ok && val_ok;
  end

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      rel_edge <= 1'b1;
      ERR      <= 1'b0;
    end else begin
      rel_edge <= 1'b0;
      ERR      <= wr_q && !(sel_ok && val_ok);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_wr[i] = wr_ok && (DIV_SEL == 4'(i));
    prog_freq_div_ch #(.DW(DW), .DEF_DIV(DEF_DIV)) u_ch (
      .CLK_in  (CLK_in),
      .RST     (RST),
      .en      (EN[i]),
      .wr      (ch_wr[i]),
      .wval    (DIV_VAL),
      .clk_out (CLK_OUT[i]),
      .tick    (TICK[i]),
      .busy    (BUSY[i])
    );
  end
endmodule

// File: tb/tb_prog_freq_div.sv
module tb_prog_freq_div;
  localparam int NCH = 4, DW = 8, DEF_DIV = 2;

  logic           CLK_in = 1'b0;
  logic           RST;
  logic [NCH-1:0] EN;
  logic           DIV_WR;
  logic [3:0]     DIV_SEL;
  logic [DW-1:0]  DIV_VAL;
  logic [NCH-1:0] CLK_OUT, TICK, BUSY;
  logic           ERR;

  prog_freq_div #(.NCH(NCH), .DW(DW), .DEF_DIV(DEF_DIV)) dut (
    .CLK_in(CLK_in), .RST(RST), .EN(EN), .DIV_WR(DIV_WR), .DIV_SEL(DIV_SEL),
    .DIV_VAL(DIV_VAL), .CLK_OUT(CLK_OUT), .TICK(TICK), .BUSY(BUSY), .ERR(ERR));

  always #5 CLK_in = ~CLK_in;

  typedef struct packed {
    logic [NCH-1:0] co, tk, bz;
    logic           er;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  bit   done = 0;

  // Reference model: each channel is described by its divisor, its position
  // within the current period, and an optional queued divisor.
  int md[NCH], mp[NCH], mpos[NCH];
  bit mpend[NCH];
  bit mfirst;

  task automatic model(input bit rst, input logic [NCH-1:0] en, input bit wr,
                       input int sel, input int val);
    exp_t e;
    bit   acc, bnd;
    int   h;
    e = '0;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        md[i] = DEF_DIV; mp[i] = DEF_DIV; mpos[i] = 0; mpend[i] = 0;
      end
      mfirst = 1;
    end else begin
      acc    = wr && !mfirst && sel < NCH && val >= 2;
      e.er   = wr && !mfirst && !(sel < NCH && val >= 2);
      mfirst = 0;
      for (int i = 0; i < NCH; i++) begin
        h   = (md[i] + 1) / 2;          // low half is ceil(D/2) cycles
        bnd = !en[i] || mpos[i] == md[i] - 1;
        if (en[i]) begin
          mpos[i]  = (mpos[i] + 1) % md[i];
          e.co[i]  = mpos[i] >= h;
          e.tk[i]  = mpos[i] == h;
        end else mpos[i] = 0;
        if (mpend[i] && bnd) begin md[i] = mp[i]; mpend[i] = 0; end
        if (acc && sel == i) begin mp[i] = val; mpend[i] = 1; end
        e.bz[i] = mpend[i];
      end
    end
    q.push_back(e);
  endtask

  // Drive one cycle's inputs at negedge and queue the post-edge expectation.
  task automatic cyc(input bit rst, input logic [NCH-1:0] en, input bit wr,
                     input int sel, input int val);
    @(negedge CLK_in);
    RST = rst; EN = en; DIV_WR = wr; DIV_SEL = 4'(sel); DIV_VAL = DW'(val);
    model(rst, en, wr, sel, val);
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en);
    for (int k = 0; k < n; k++) cyc(0, en, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_in);
      #1;
      if (done) break;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL underflow: no expectation queued at t=%0t", $time);
      end else begin
        e = q.pop_front();
        if (CLK_OUT !== e.co) begin bad++; $display("FAIL clk_out t=%0t got=%b exp=%b", $time, CLK_OUT, e.co); end
        total++;
        if (TICK !== e.tk) begin bad++; $display("FAIL tick t=%0t got=%b exp=%b", $time, TICK, e.tk); end
        total++;
        if (BUSY !== e.bz) begin bad++; $display("FAIL busy t=%0t got=%b exp=%b", $time, BUSY, e.bz); end
        total++;
        if (ERR !== e.er) begin bad++; $display("FAIL err t=%0t got=%b exp=%b", $time, ERR, e.er); end
      end
    end
  end

  initial begin
    logic [NCH-1:0] en;
    int sel, val, r;
    // Reset is applied before the first edge.
    RST = 1; EN = '1; DIV_WR = 0; DIV_SEL = 0; DIV_VAL = 0;
    model(1, '1, 0, 0, 0);
    cyc(1, '1, 0, 0, 0);
    // Write on the release edge must be ignored.
    cyc(0, '1, 1, 1, 7);
    // Defaults: every channel divides by 2.
    idle(12, '1);
    // ch1 <- 10, ch2 <- 5, ch0 <- 100.
    cyc(0, '1, 1, 1, 10);
    cyc(0, '1, 1, 2, 5);
    cyc(0, '1, 1, 0, 100);
    idle(25, '1);
    // Shrink ch0 mid-period; old period must complete first.
    cyc(0, '1, 1, 0, 4);
    idle(110, '1);
    // Rejected writes: too small, out-of-range channel.
    cyc(0, '1, 1, 3, 1);
    idle(2, '1);
    cyc(0, '1, 1, NCH, 9);
    idle(2, '1);
    // Back-to-back writes to ch3 around its wraps (overwrite + same-edge case).
    for (int k = 0; k < 12; k++) cyc(0, '1, 1, 3, 2 + (k % 4));
    idle(10, '1);
    // Drop EN[3] mid-period, then a reset pulse with a write pending.
    idle(3, 4'b0111);
    cyc(0, 4'b0111, 1, 1, 6);
    cyc(1, '1, 0, 0, 0);
    idle(10, '1);
    // Random traffic.
    en = '1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
      r   = $urandom_range(0, 99);
      sel = ($urandom_range(0, 9) == 0) ? $urandom_range(NCH, 15) : $urandom_range(0, NCH - 1);
      val = (r < 5) ? $urandom_range(0, 1) : (r < 15) ? $urandom_range(2, 255) : $urandom_range(2, 12);
      cyc($urandom_range(0, 299) == 0, en, $urandom_range(0, 3) == 0, sel, val);
    end
    @(posedge CLK_in);
    #2;
    done = 1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover: queue holds %0d entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
